// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory bus between the instruction
// fetch port (I) and the load/store port (D).
//
// D has priority. While I is pending, D gets at most MAX_D_STREAK consecutive
// grants, then I is served. A transaction that sees no i_MAck for TIMEOUT
// cycles is aborted, and the requester gets a one-cycle error pulse.
// All outputs are registered.
//
// Ports:
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_IReq / i_IAddr     fetch request and address
//   o_IRData/o_IAck/o_IErr  fetch read data, done pulse, timeout pulse
//   i_DReq/i_DWe/i_DAddr/i_DWData/i_DBe  load/store request
//   o_DRData/o_DAck/o_DErr  load/store read data, done pulse, timeout pulse
//   o_MReq/o_MWe/o_MAddr/o_MWData/o_MBe  memory request fields
//   i_MRData/i_MAck      memory read data and acknowledge
//   o_Busy               arbiter is not idle
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_IReq,
  input  logic [ADDR_W-1:0]     i_IAddr,
  output logic [DATA_W-1:0]     o_IRData,
  output logic                  o_IAck,
  output logic                  o_IErr,
  input  logic                  i_DReq,
  input  logic                  i_DWe,
  input  logic [ADDR_W-1:0]     i_DAddr,
  input  logic [DATA_W-1:0]     i_DWData,
  input  logic [DATA_W/8-1:0]   i_DBe,
  output logic [DATA_W-1:0]     o_DRData,
  output logic                  o_DAck,
  output logic                  o_DErr,
  output logic                  o_MReq,
  output logic                  o_MWe,
  output logic [ADDR_W-1:0]     o_MAddr,
  output logic [DATA_W-1:0]     o_MWData,
  output logic [DATA_W/8-1:0]   o_MBe,
  input  logic [DATA_W-1:0]     i_MRData,
  input  logic                  i_MAck,
  output logic                  o_Busy
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          ToEn = (TIMEOUT != 0);
  localparam logic [CntW-1:0] ToLast = CntW'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));
  localparam logic [3:0]      MaxStreak = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          streak_q, streak_d;
  logic [CntW-1:0]     to_cnt_q, to_cnt_d;
  logic                mreq_q, mreq_d;
  logic                mwe_q, mwe_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   mwdata_q, mwdata_d;
  logic [BeW-1:0]      mbe_q, mbe_d;
  logic [DATA_W-1:0]   irdata_q, irdata_d;
  logic [DATA_W-1:0]   drdata_q, drdata_d;
  logic                iack_q, iack_d;
  logic                ierr_q, ierr_d;
  logic                dack_q, dack_d;
  logic                derr_q, derr_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    to_cnt_d = to_cnt_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mbe_d    = mbe_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    // Completion flags are single-cycle pulses.
    iack_d   = 1'b0;
    ierr_d   = 1'b0;
    dack_d   = 1'b0;
    derr_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_DReq && (!i_IReq || (streak_q < MaxStreak))) begin
          mwe_d    = i_DWe;
          maddr_d  = i_DAddr;
          mwdata_d = i_DWData;
          mbe_d    = i_DBe;
          mreq_d   = 1'b1;
          state_d  = StBusyD;
          // Only count D grants that made a waiting I request wait longer.
          if (i_IReq) begin
            streak_d = (streak_q == MaxStreak) ? streak_q : streak_q + 4'd1;
          end else begin
            streak_d = '0;
          end
        end else if (i_IReq) begin
          mwe_d    = 1'b0;
          maddr_d  = i_IAddr;
          mbe_d    = '1;
          mreq_d   = 1'b1;
          state_d  = StBusyI;
          streak_d = '0;
        end
      end

      StBusyI, StBusyD: begin
        // An ack on the last allowed cycle beats the timeout.
        if (i_MAck) begin
          if (state_q == StBusyI) begin
            irdata_d = i_MRData;
            iack_d   = 1'b1;
          end else begin
            drdata_d = i_MRData;
            dack_d   = 1'b1;
          end
          mreq_d  = 1'b0;
          state_d = StResp;
        end else if (ToEn && (to_cnt_q == ToLast)) begin
          if (state_q == StBusyI) begin
            ierr_d = 1'b1;
          end else begin
            derr_d = 1'b1;
          end
          mreq_d  = 1'b0;
          state_d = StResp;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StResp: begin
        // Requests are ignored here so a requester has one cycle to drop req.
        to_cnt_d = '0;
        state_d  = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      streak_q <= '0;
      to_cnt_q <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbe_q    <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      iack_q   <= 1'b0;
      ierr_q   <= 1'b0;
      dack_q   <= 1'b0;
      derr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      to_cnt_q <= to_cnt_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mbe_q    <= mbe_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iack_q   <= iack_d;
      ierr_q   <= ierr_d;
      dack_q   <= dack_d;
      derr_q   <= derr_d;
      busy_q   <= busy_d;
    end
  end

  assign o_IRData = irdata_q;
  assign o_IAck   = iack_q;
  assign o_IErr   = ierr_q;
  assign o_DRData = drdata_q;
  assign o_DAck   = dack_q;
  assign o_DErr   = derr_q;
  assign o_MReq   = mreq_q;
  assign o_MWe    = mwe_q;
  assign o_MAddr  = maddr_q;
  assign o_MWData = mwdata_q;
  assign o_MBe    = mbe_q;
  assign o_Busy   = busy_q;

endmodule
